prbs_training_checker: RTL and testbench
========================================

// Module: prbs_training_checker
// PURPOSE
//  Receive end of the calibration PRBS training signal. Slices one lane of one ADC channel's
//  per-clock sample word into one bit per adcClk, self-synchronises to the 15-bit XNOR PRBS
//  (x^15+x^14+1, tap 13, newest bit at LSB, generator reset state all-zeros), verifies lock,
//  then counts bit errors over a fixed window. Results feed the calibration CSR readout.
// PARAMETERS
//  ADC_WIDTH          14   significant (MSB-justified) bits per sample
//  SAMPLES_PER_CLOCK  8    samples per adcTDATA word
//  AXI_SAMPLE_WIDTH   16   bits per sample slot in adcTDATA
//  PRBS_SHIFT_WIDTH   15   PRBS register length
//  PRBS_SHIFT_TAP     13   second feedback tap
//  LOCK_COUNT         64   consecutive correct predictions required for lock
//  WINDOW_LOG2        20   measurement window = 2**WINDOW_LOG2 valid bits
//  ERR_WIDTH          16   error counter width (saturating)
// PORTS
//  adcClk       in   1                                  sole clock
//  adcReset     in   1                                  synchronous, active-high
//  enable       in   1                                  level; run request
//  laneSelect   in   $clog2(SAMPLES_PER_CLOCK)          sample slot carrying the bit
//  threshold    in   ADC_WIDTH                          signed slicer threshold
//  adcTVALID    in   1                                  adcTDATA qualifier
//  adcTDATA     in   SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH single-channel sample word
//  state        out  3                                  FSM state, status readout
//  locked       out  1                                  high in MEASURE and DONE
//  done         out  1                                  high in DONE
//  errorCount   out  ERR_WIDTH                          window errors, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=IDLE(0), locked=0, done=0, errorCount=0, history=0, all counters 0.
//  - Slicer (1 register stage): sample=adcTDATA[(laneSelL+1)*AXI_SAMPLE_WIDTH-1-:ADC_WIDTH];
//    bit = ($signed(sample) >= $signed(threshL)); bitValid = adcTVALID delayed 1 clock.
//  - laneSelL/threshL latched on IDLE->SEED only; later changes ignored until next run.
//  - predicted = !(hist[14] ^ hist[13]). History shifts {hist[13:0],bit} on every bitValid
//    in SEED/VERIFY/MEASURE (checker is self-synchronous; errors do not corrupt prediction
//    beyond 2 following bits).
//  - mismatch = bitValid && (bit != predicted || hist == all-ones). All-ones = XNOR lockup.
//  - FSM (any state, !enable -> IDLE next clock; done/errorCount hold until next SEED entry):
//    IDLE(0):    enable -> SEED; clear errorCount, seedCnt, goodRun, bitCount, done.
//    SEED(1):    seedCnt++ per bitValid; after 15th valid bit -> VERIFY, goodRun=0.
//    VERIFY(2):  match: goodRun++; goodRun reaching LOCK_COUNT -> MEASURE (locked=1 next clk).
//                mismatch: -> SEED with seedCnt=0 (history retained, not cleared).
//    MEASURE(3): bitCount++ per bitValid; mismatch -> errorCount++ unless all-ones.
//                bit that makes bitCount == 2**WINDOW_LOG2 is counted, then -> DONE.
//    DONE(4):    done=1, locked=1, outputs frozen; leave only via !enable or reset.
//  - bitCount width WINDOW_LOG2+1; no wrap. errorCount never wraps.
//  - adcTVALID low: no shift, no count, state holds.
//  - Reset mid-run overrides enable; restart needs enable high after reset (IDLE->SEED).
//  - Latency: adcTDATA bit to errorCount update = 2 clocks.
// STRUCTURE
//  - Shared package calibration_pkg: PRBS_SHIFT_WIDTH/PRBS_SHIFT_TAP constants (shared with
//    the generator), state encoding localparams, prbs_next() function.
//  - One sub-module: training_slicer (lane mux + signed compare + valid delay).
// TESTING
//  1 Generator model from all-zeros, thresh=0, lane 3, samples +/-4000 -> locked after
//    15+64 valid bits, done after 2**20 more, errorCount=0.
//  2 Inject 10 single-bit flips in MEASURE, >=20 bits apart -> errorCount=30 (each flip = 3).
//  3 Constant +4000 input (all-ones history) -> never leaves SEED/VERIFY, locked=0.
//  4 One flip at VERIFY goodRun=40 -> back to SEED, lock at 40+15+64 bits, errorCount=0.
//  5 Random bits, ERR_WIDTH=4 -> errorCount saturates at 15, done still asserts.
//  6 adcTVALID 50% duty; enable drop in MEASURE -> IDLE next clock; adcReset -> all outputs 0.

Source files
------------

// File: rtl/calibration_pkg.sv
// Shared calibration definitions.
//   PRBS_SHIFT_WIDTH / PRBS_SHIFT_TAP : training PRBS polynomial x^15+x^14+1 (XNOR form),
//                                       shared with the training generator.
//   ST_*                              : training checker FSM encoding (status readout value).
//   prbs_next()                       : next PRBS bit predicted from a history register that
//                                       holds the newest bit at the LSB.
package calibration_pkg;

  localparam int PRBS_SHIFT_WIDTH = 15;
  localparam int PRBS_SHIFT_TAP   = 13;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEED    = 3'd1;
  localparam logic [2:0] ST_VERIFY  = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic logic prbs_next(input logic [PRBS_SHIFT_WIDTH-1:0] hist);
    return ~(hist[PRBS_SHIFT_WIDTH-1] ^ hist[PRBS_SHIFT_TAP]);
  endfunction

endpackage

// File: rtl/training_slicer.sv
// Training-bit slicer: picks one sample slot out of the per-clock sample word, compares its
// MSB-justified ADC value against a signed threshold and registers the resulting bit.
//   adcClk, adcReset : clock, synchronous active-high reset
//   laneSel          : sample slot carrying the training bit
//   thresh           : signed slicer threshold (ADC_WIDTH bits)
//   adcTVALID/TDATA  : sample word and its qualifier
//   sliceBit         : sample >= thresh, one clock after the word
//   bitValid         : adcTVALID delayed by one clock
module training_slicer #(
  parameter int ADC_WIDTH         = 14,
  parameter int SAMPLES_PER_CLOCK = 8,
  parameter int AXI_SAMPLE_WIDTH  = 16
) (
  input  logic                                          adcClk,
  input  logic                                          adcReset,
  input  logic [$clog2(SAMPLES_PER_CLOCK)-1:0]          laneSel,
  input  logic [ADC_WIDTH-1:0]                          thresh,
  input  logic                                          adcTVALID,
  input  logic [SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] adcTDATA,
  output logic                                          sliceBit,
  output logic                                          bitValid
);

  logic [SAMPLES_PER_CLOCK-1:0][AXI_SAMPLE_WIDTH-1:0] slots;
  logic [AXI_SAMPLE_WIDTH-1:0]                        slot;
  logic [ADC_WIDTH-1:0]                               sample;

  assign slots  = adcTDATA;
  assign slot   = slots[laneSel];
  // ADC data is MSB-justified in its slot; the low pad bits are ignored.
  assign sample = slot[AXI_SAMPLE_WIDTH-1 -: ADC_WIDTH];

  // NOTE: registers are written with <= so every flop samples pre-edge values together.
  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      sliceBit <= 1'b0;
      bitValid <= 1'b0;
    end else begin
      sliceBit <= ($signed(sample) >= $signed(thresh));
      bitValid <= adcTVALID;
    end
  end

endmodule

// File: rtl/prbs_training_checker.sv
// Receive-side checker for the calibration PRBS training pattern.
// Slices one lane into one bit per clock, self-synchronises to the XNOR PRBS15, requires
// LOCK_COUNT consecutive correct predictions for lock, then counts bit errors over a window
// of 2**WINDOW_LOG2 valid bits.
//   adcClk, adcReset : clock, synchronous active-high reset
//   enable           : run request (level); low returns to IDLE on the next clock
//   laneSelect       : sample slot carrying the bit (captured at run start)
//   threshold        : signed slicer threshold (captured at run start)
//   adcTVALID/TDATA  : single-channel sample word
//   state            : FSM state for status readout
//   locked           : high in MEASURE and DONE
//   done             : set on window completion, held until the next run starts
//   errorCount       : saturating error count of the last window
module prbs_training_checker
  import calibration_pkg::*;
#(
  parameter int ADC_WIDTH         = 14,
  parameter int SAMPLES_PER_CLOCK = 8,
  parameter int AXI_SAMPLE_WIDTH  = 16,
  parameter int LOCK_COUNT        = 64,
  parameter int WINDOW_LOG2       = 20,
  parameter int ERR_WIDTH         = 16
) (
  input  logic                                          adcClk,
  input  logic                                          adcReset,
  input  logic                                          enable,
  input  logic [$clog2(SAMPLES_PER_CLOCK)-1:0]          laneSelect,
  input  logic [ADC_WIDTH-1:0]                          threshold,
  input  logic                                          adcTVALID,
  input  logic [SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] adcTDATA,
  output logic [2:0]                                    state,
  output logic                                          locked,
  output logic                                          done,
  output logic [ERR_WIDTH-1:0]                          errorCount
);

  localparam int LANE_WIDTH = $clog2(SAMPLES_PER_CLOCK);
  localparam int SEED_WIDTH = $clog2(PRBS_SHIFT_WIDTH + 1);
  localparam int RUN_WIDTH  = $clog2(LOCK_COUNT + 1);
  localparam int CNT_WIDTH  = WINDOW_LOG2 + 1;

  localparam logic [SEED_WIDTH-1:0] SEED_LAST   = SEED_WIDTH'(PRBS_SHIFT_WIDTH - 1);
  localparam logic [RUN_WIDTH-1:0]  RUN_LAST    = RUN_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0]  WINDOW_LAST = {1'b0, {WINDOW_LOG2{1'b1}}};

  logic [2:0]                  stateQ, stateNext;
  logic [LANE_WIDTH-1:0]       laneSelL, laneSelEff;
  logic [ADC_WIDTH-1:0]        threshL, threshEff;
  logic                        sliceBit, bitValid;
  logic [PRBS_SHIFT_WIDTH-1:0] hist;
  logic [SEED_WIDTH-1:0]       seedCnt;
  logic [RUN_WIDTH-1:0]        goodRun;
  logic [CNT_WIDTH-1:0]        bitCount;
  logic                        predicted, allOnes, mismatch, errorHit, inRun;

  // In IDLE the slicer follows the live controls, so the bit sliced on the IDLE->SEED edge
  // already uses the values captured on that same edge.
  assign laneSelEff = (stateQ == ST_IDLE) ? laneSelect : laneSelL;
  assign threshEff  = (stateQ == ST_IDLE) ? threshold  : threshL;

  training_slicer #(
    .ADC_WIDTH        (ADC_WIDTH),
    .SAMPLES_PER_CLOCK(SAMPLES_PER_CLOCK),
    .AXI_SAMPLE_WIDTH (AXI_SAMPLE_WIDTH)
  ) uSlicer (
    .adcClk   (adcClk),
    .adcReset (adcReset),
    .laneSel  (laneSelEff),
    .thresh   (threshEff),
    .adcTVALID(adcTVALID),
    .adcTDATA (adcTDATA),
    .sliceBit (sliceBit),
    .bitValid (bitValid)
  );

  // All-ones is the XNOR lockup state: it predicts itself forever, so it is never a match.
  assign predicted = prbs_next(hist);
  assign allOnes   = &hist;
  assign mismatch  = bitValid && ((sliceBit != predicted) || allOnes);
  assign errorHit  = bitValid && (sliceBit != predicted) && !allOnes;
  assign inRun     = (stateQ == ST_SEED) || (stateQ == ST_VERIFY) || (stateQ == ST_MEASURE);

  always_ff @(posedge adcClk) begin
    if (adcReset) stateQ <= ST_IDLE;
    else          stateQ <= stateNext;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      ST_IDLE:    stateNext = ST_SEED;
      ST_SEED:    if (bitValid && (seedCnt == SEED_LAST)) stateNext = ST_VERIFY;
      ST_VERIFY:  if (bitValid) begin
                    if (mismatch)                 stateNext = ST_SEED;
                    else if (goodRun == RUN_LAST) stateNext = ST_MEASURE;
                  end
      ST_MEASURE: if (bitValid && (bitCount == WINDOW_LAST)) stateNext = ST_DONE;
      ST_DONE:    stateNext = ST_DONE;
      default:    stateNext = ST_IDLE;
    endcase
    if (!enable) stateNext = ST_IDLE;
  end

  always_comb begin
    state  = stateQ;
    locked = (stateQ == ST_MEASURE) || (stateQ == ST_DONE);
  end

  always_ff @(posedge adcClk) begin
    if (adcReset) begin
      hist       <= '0;
      laneSelL   <= '0;
      threshL    <= '0;
      seedCnt    <= '0;
      goodRun    <= '0;
      bitCount   <= '0;
      errorCount <= '0;
      done       <= 1'b0;
    end else begin
      // Self-synchronous: the received bit, right or wrong, becomes history.
      if (bitValid && inRun) hist <= {hist[PRBS_SHIFT_WIDTH-2:0], sliceBit};

      case (stateQ)
        ST_IDLE: if (enable) begin
          laneSelL   <= laneSelect;
          threshL    <= threshold;
          seedCnt    <= '0;
          goodRun    <= '0;
          bitCount   <= '0;
          errorCount <= '0;
          done       <= 1'b0;
        end
        ST_SEED: if (bitValid) begin
          seedCnt <= seedCnt + 1'b1;
          if (seedCnt == SEED_LAST) goodRun <= '0;
        end
        ST_VERIFY: if (bitValid) begin
          if (mismatch) seedCnt <= '0;
          else          goodRun <= goodRun + 1'b1;
        end
        ST_MEASURE: if (bitValid) begin
          bitCount <= bitCount + 1'b1;
          if (errorHit && (errorCount != '1)) errorCount <= errorCount + 1'b1;
          if (stateNext == ST_DONE) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_training_checker.sv
// Randomized bench for prbs_training_checker. Two instances share the stimulus: one with a
// 16-bit error counter and one with a 4-bit counter to exercise saturation. A bit-stream
// level reference model (history kept as a queue of bits, counts as plain integers) predicts
// the status outputs every clock; scenario milestones are also checked against fixed values.
module tb_prbs_training_checker;

  localparam int ADC_WIDTH         = 14;
  localparam int SAMPLES_PER_CLOCK = 8;
  localparam int AXI_SAMPLE_WIDTH  = 16;
  localparam int WINDOW_LOG2       = 10;
  localparam int LOCK_COUNT        = 64;
  localparam int WINDOW            = 1 << WINDOW_LOG2;
  localparam int SEED_BITS         = 15;
  localparam int TO_LOCK           = SEED_BITS + LOCK_COUNT;

  logic adcClk = 1'b0;
  logic adcReset, enable, adcTVALID;
  logic [2:0] laneSelect;
  logic [ADC_WIDTH-1:0] threshold;
  logic [SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] adcTDATA;
  logic [2:0] state, stateS;
  logic locked, lockedS, done, doneS;
  logic [15:0] errorCount;
  logic [3:0] errorCountS;

  always #5 adcClk = ~adcClk;

  prbs_training_checker #(.WINDOW_LOG2(WINDOW_LOG2), .ERR_WIDTH(16)) dut (
    .adcClk(adcClk), .adcReset(adcReset), .enable(enable), .laneSelect(laneSelect),
    .threshold(threshold), .adcTVALID(adcTVALID), .adcTDATA(adcTDATA),
    .state(state), .locked(locked), .done(done), .errorCount(errorCount)
  );

  prbs_training_checker #(.WINDOW_LOG2(WINDOW_LOG2), .ERR_WIDTH(4)) dutSat (
    .adcClk(adcClk), .adcReset(adcReset), .enable(enable), .laneSelect(laneSelect),
    .threshold(threshold), .adcTVALID(adcTVALID), .adcTDATA(adcTDATA),
    .state(stateS), .locked(lockedS), .done(doneS), .errorCount(errorCountS)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus state
  int gReg      = 0;     // PRBS generator register, starts all-zeros
  int dataLane  = 3;     // slot the training bit is placed in
  int curThr    = 0;     // slicer threshold as an integer
  int marginFix = 4000;  // nonzero: fixed +/- level around threshold; zero: random margin
  int laneVal [SAMPLES_PER_CLOCK];

  // Reference model state (phase numbers are the status readout values)
  int mPhase, mSeed, mGood, mBits, mErrs, mLane, mThresh;
  bit mDone, pValid, pBit;
  bit mHist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit prbsBit();
    bit nb;
    nb   = ~(gReg[14] ^ gReg[13]);
    gReg = ((gReg << 1) | int'(nb)) & 32'h7fff;
    return nb;
  endfunction

  function automatic int levelFor(input bit b);
    int m;
    if (marginFix != 0) return b ? curThr + marginFix : curThr - marginFix;
    m = int'($urandom_range(0, 2000));
    return b ? curThr + m : curThr - 1 - m;  // m == 0 lands exactly on the threshold
  endfunction

  task automatic modelReset();
    mPhase = 0; mSeed = 0; mGood = 0; mBits = 0; mErrs = 0; mLane = 0; mThresh = 0;
    mDone = 1'b0; pValid = 1'b0; pBit = 1'b0;
    mHist.delete();
    for (int i = 0; i < SEED_BITS; i++) mHist.push_back(1'b0);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelClock();
    int nxt, ones, lane, thr;
    bit pred, wrong, allOnes;
    if (adcReset) begin
      modelReset();
      return;
    end
    nxt = mPhase;
    if (pValid && mPhase >= 1 && mPhase <= 3) begin
      pred = ~(mHist[0] ^ mHist[1]);  // oldest two bits of the last 15
      ones = 0;
      foreach (mHist[i]) ones += int'(mHist[i]);
      allOnes = (ones == SEED_BITS);
      wrong   = (pBit != pred);
      case (mPhase)
        1: begin
          mSeed++;
          if (mSeed == SEED_BITS) begin nxt = 2; mGood = 0; end
        end
        2: begin
          if (wrong || allOnes) begin nxt = 1; mSeed = 0; end
          else begin
            mGood++;
            if (mGood == LOCK_COUNT) nxt = 3;
          end
        end
        default: begin
          mBits++;
          if (wrong && !allOnes) mErrs++;
          if (mBits == WINDOW) nxt = 4;
        end
      endcase
      void'(mHist.pop_front());
      mHist.push_back(pBit);
    end
    if (mPhase == 0 && enable) begin
      nxt = 1; mLane = int'(laneSelect); mThresh = curThr;
      mSeed = 0; mGood = 0; mBits = 0; mErrs = 0; mDone = 1'b0;
    end
    if (!enable) nxt = 0;
    if (mPhase == 3 && nxt == 4) mDone = 1'b1;
    lane   = (mPhase == 0) ? int'(laneSelect) : mLane;
    thr    = (mPhase == 0) ? curThr : mThresh;
    pBit   = (laneVal[lane] >= thr);
    pValid = adcTVALID;
    mPhase = nxt;
  endtask

  task automatic compareAll();
    check("state", state, mPhase);
    check("locked", locked, (mPhase == 3) || (mPhase == 4));
    check("done", done, mDone);
    check("errorCount", errorCount, sat(mErrs, 65535));
    check("stateSat", stateS, mPhase);
    check("doneSat", doneS, mDone);
    check("errorCountSat", errorCountS, sat(mErrs, 15));
  endtask

  // One clock: drive at the falling edge, model, then compare after the rising edge.
  task automatic tick(input bit valid, input bit b);
    logic [1:0] pad;
    for (int i = 0; i < SAMPLES_PER_CLOCK; i++) laneVal[i] = int'($urandom_range(0, 16383)) - 8192;
    laneVal[dataLane] = levelFor(b);
    for (int i = 0; i < SAMPLES_PER_CLOCK; i++) begin
      pad = 2'($urandom_range(0, 3));
      adcTDATA[i*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH] = {laneVal[i][ADC_WIDTH-1:0], pad};
    end
    adcTVALID = valid;
    modelClock();
    @(posedge adcClk);
    @(negedge adcClk);
    compareAll();
  endtask

  task automatic sendPrbs(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, prbsBit());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic restart();
    enable     = 1'b0;
    laneSelect = 3'(dataLane);
    threshold  = ADC_WIDTH'(curThr);
    tick(1'b0, 1'b0);
    enable = 1'b1;
  endtask

  initial begin
    bit b;
    int guard;
    modelReset();
    adcReset = 1'b1; enable = 1'b0; adcTVALID = 1'b0; adcTDATA = '0;
    laneSelect = 3'd3; threshold = '0;

    // Reset state
    idle(3);
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_done", done, 0);
    check("rst_errorCount", errorCount, 0);
    adcReset = 1'b0;
    idle(1);

    // 1: clean PRBS on lane 3, lock after exactly 15+64 bits, clean window
    enable = 1'b1;
    sendPrbs(1);
    laneSelect = 3'd6;  // must be ignored until the next run
    sendPrbs(TO_LOCK - 2);
    idle(1);
    check("t1_unlocked_at_78", locked, 0);
    sendPrbs(1);
    idle(1);
    check("t1_locked_at_79", locked, 1);
    sendPrbs(WINDOW - 1);
    idle(1);
    check("t1_done_before_last", done, 0);
    sendPrbs(1);
    idle(1);
    check("t1_done", done, 1);
    check("t1_state_done", state, 4);
    check("t1_errorCount", errorCount, 0);
    sendPrbs(20);
    check("t1_done_frozen", state, 4);
    enable = 1'b0;
    idle(1);
    check("t1_idle_after_drop", state, 0);
    check("t1_done_held", done, 1);

    // 2: ten isolated flips in MEASURE, three errors each
    restart();
    sendPrbs(TO_LOCK);
    for (int k = 0; k < WINDOW; k++) begin
      b = prbsBit();
      if (k >= 100 && k < 700 && ((k - 100) % 60) == 0) b = ~b;
      tick(1'b1, b);
    end
    idle(1);
    check("t2_errorCount", errorCount, 30);
    check("t2_errorCount_sat", errorCountS, 15);
    check("t2_done", done, 1);

    // 4: flip during VERIFY at goodRun=40 forces a full reseed
    restart();
    sendPrbs(SEED_BITS + 40);
    tick(1'b1, ~prbsBit());
    sendPrbs(TO_LOCK - 1);
    idle(1);
    check("t4_unlocked_after_reseed", locked, 0);
    sendPrbs(1);
    idle(1);
    check("t4_locked", locked, 1);
    check("t4_errorCount", errorCount, 0);

    // 5: random bits after lock saturate the narrow counter
    restart();
    sendPrbs(TO_LOCK);
    for (int k = 0; k < WINDOW; k++) tick(1'b1, 1'($urandom_range(0, 1)));
    idle(1);
    check("t5_errorCount_sat", errorCountS, 15);
    check("t5_done_sat", doneS, 1);
    check("t5_done", done, 1);
    check("t5_many_errors", errorCount > 16'd15, 1);

    // Reset mid-state clears everything; enable still high restarts straight away
    adcReset = 1'b1;
    tick(1'b1, prbsBit());
    check("rst2_state", state, 0);
    check("rst2_done", done, 0);
    check("rst2_errorCount", errorCount, 0);
    adcReset = 1'b0;
    tick(1'b0, 1'b0);
    check("rst2_reenter_seed", state, 1);

    // 3: constant +4000 drives the history into lockup, never locks
    restart();
    for (int k = 0; k < 300; k++) tick(1'b1, 1'b1);
    check("t3_locked", locked, 0);
    check("t3_state_seed_verify", (state == 3'd1) || (state == 3'd2), 1);

    // 6: random lane/threshold, 50% valid duty, enable drop in MEASURE
    dataLane  = int'($urandom_range(0, 7));
    curThr    = int'($urandom_range(0, 6000)) - 3000;
    marginFix = 0;
    restart();
    guard = 0;
    while (mPhase != 3 && guard < 2000) begin
      if ($urandom_range(0, 1) == 1) tick(1'b1, prbsBit());
      else                           tick(1'b0, 1'b0);
      guard++;
    end
    check("t6_locked", locked, 1);
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 1) == 1) tick(1'b1, prbsBit());
      else                           tick(1'b0, 1'b0);
    end
    check("t6_still_measuring", state, 3);
    enable = 1'b0;
    tick(1'b1, prbsBit());
    check("t6_idle_after_drop", state, 0);
    check("t6_unlocked_after_drop", locked, 0);
    enable = 1'b1;
    sendPrbs(5);
    adcReset = 1'b1;
    tick(1'b1, prbsBit());
    check("t6_rst_state", state, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_errorCount", errorCount, 0);
    adcReset = 1'b0;
    enable   = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
